// File: rtl/video_pkg.sv
// Shared definitions for the video timing / test pattern blocks.
package video_pkg;

  typedef enum logic [1:0] {
    PAT_BARS     = 2'd0,
    PAT_CHECKER  = 2'd1,
    PAT_GRADIENT = 2'd2,
    PAT_SOLID    = 2'd3
  } pattern_e;

  // Colour-bar table, left to right across the active line.
  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = 24'hFFFFFF;
      3'd1:    c = 24'hFFFF00;
      3'd2:    c = 24'h00FFFF;
      3'd3:    c = 24'h00FF00;
      3'd4:    c = 24'hFF00FF;
      3'd5:    c = 24'hFF0000;
      3'd6:    c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

  function automatic int video_total(input int res, input int fp, input int pulse, input int bp);
    return res + fp + pulse + bp;
  endfunction

endpackage

// File: rtl/video_raster_counter.sv
// Horizontal/vertical raster counters with combinational sync and blank decode.
// Line and frame ordering: active, front porch, sync, back porch.
module video_raster_counter
  import video_pkg::*;
#(
  parameter int   C_resolution_x      = 640,
  parameter int   C_hsync_front_porch = 16,
  parameter int   C_hsync_pulse       = 96,
  parameter int   C_hsync_back_porch  = 48,
  parameter int   C_resolution_y      = 480,
  parameter int   C_vsync_front_porch = 10,
  parameter int   C_vsync_pulse       = 2,
  parameter int   C_vsync_back_porch  = 33,
  parameter logic C_hsync_polarity    = 1'b0,
  parameter logic C_vsync_polarity    = 1'b0,
  parameter int   C_bits_x            = 12,
  parameter int   C_bits_y            = 11
) (
  input  logic                i_clk,
  input  logic                i_rst,
  output logic [C_bits_x-1:0] o_hcount,
  output logic [C_bits_y-1:0] o_vcount,
  output logic                o_hsync,
  output logic                o_vsync,
  output logic                o_blank,
  output logic                o_line_first,
  output logic                o_frame_first
);

  localparam int H_TOTAL = video_total(C_resolution_x, C_hsync_front_porch, C_hsync_pulse, C_hsync_back_porch);
  localparam int V_TOTAL = video_total(C_resolution_y, C_vsync_front_porch, C_vsync_pulse, C_vsync_back_porch);

  localparam logic [C_bits_x-1:0] H_LAST       = C_bits_x'(H_TOTAL - 1);
  localparam logic [C_bits_x-1:0] H_ACTIVE     = C_bits_x'(C_resolution_x);
  localparam logic [C_bits_x-1:0] H_SYNC_START = C_bits_x'(C_resolution_x + C_hsync_front_porch);
  localparam logic [C_bits_x-1:0] H_SYNC_END   = C_bits_x'(C_resolution_x + C_hsync_front_porch + C_hsync_pulse);
  localparam logic [C_bits_y-1:0] V_LAST       = C_bits_y'(V_TOTAL - 1);
  localparam logic [C_bits_y-1:0] V_ACTIVE     = C_bits_y'(C_resolution_y);
  localparam logic [C_bits_y-1:0] V_SYNC_START = C_bits_y'(C_resolution_y + C_vsync_front_porch);
  localparam logic [C_bits_y-1:0] V_SYNC_END   = C_bits_y'(C_resolution_y + C_vsync_front_porch + C_vsync_pulse);

  // Zero-length porches or pulses break the decode ordering; counters must hold the totals.
  if (C_resolution_x < 1 || C_hsync_front_porch < 1 || C_hsync_pulse < 1 || C_hsync_back_porch < 1 ||
      C_resolution_y < 1 || C_vsync_front_porch < 1 || C_vsync_pulse < 1 || C_vsync_back_porch < 1) begin : g_bad_timing
    $error("video_raster_counter: every resolution, porch and pulse must be at least 1");
  end
  if (H_TOTAL > (1 << C_bits_x) || V_TOTAL > (1 << C_bits_y)) begin : g_bad_width
    $error("video_raster_counter: counter width too small for the frame totals");
  end

  logic [C_bits_x-1:0] r_hcount;
  logic [C_bits_y-1:0] r_vcount;

  // Free-running raster position: x every clock, y on each x wrap.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hcount <= '0;
      r_vcount <= '0;
    end else if (r_hcount == H_LAST) begin
      r_hcount <= '0;
      r_vcount <= (r_vcount == V_LAST) ? '0 : r_vcount + 1'b1;
    end else begin
      r_hcount <= r_hcount + 1'b1;
    end
  end

  assign o_hcount      = r_hcount;
  assign o_vcount      = r_vcount;
  assign o_hsync       = (r_hcount >= H_SYNC_START && r_hcount < H_SYNC_END) ? C_hsync_polarity : ~C_hsync_polarity;
  assign o_vsync       = (r_vcount >= V_SYNC_START && r_vcount < V_SYNC_END) ? C_vsync_polarity : ~C_vsync_polarity;
  assign o_blank       = (r_hcount >= H_ACTIVE) || (r_vcount >= V_ACTIVE);
  assign o_line_first  = (r_hcount == '0);
  assign o_frame_first = (r_hcount == '0) && (r_vcount == '0);

endmodule

// File: rtl/video_timing_pattern.sv
// Raster timing plus frame-synchronous test pattern generator for the pixel clock domain.
// Every output is registered one cycle after the raster position it describes.
module video_timing_pattern
  import video_pkg::*;
#(
  parameter int   C_resolution_x      = 640,
  parameter int   C_hsync_front_porch = 16,
  parameter int   C_hsync_pulse       = 96,
  parameter int   C_hsync_back_porch  = 48,
  parameter int   C_resolution_y      = 480,
  parameter int   C_vsync_front_porch = 10,
  parameter int   C_vsync_pulse       = 2,
  parameter int   C_vsync_back_porch  = 33,
  parameter logic C_hsync_polarity    = 1'b0,
  parameter logic C_vsync_polarity    = 1'b0,
  parameter int   C_checker_log2      = 5,
  parameter int   C_bits_x            = 12,
  parameter int   C_bits_y            = 11
) (
  input  logic                clk_pixel,
  input  logic                reset,
  input  logic [1:0]          mode,
  input  logic [23:0]         solid_rgb,
  output logic [7:0]          vga_r,
  output logic [7:0]          vga_g,
  output logic [7:0]          vga_b,
  output logic                vga_hsync,
  output logic                vga_vsync,
  output logic                vga_blank,
  output logic [C_bits_x-1:0] pixel_x,
  output logic [C_bits_y-1:0] pixel_y,
  output logic                line_start,
  output logic                frame_start,
  output logic [7:0]          frame_count
);

  localparam int                  BAR_W   = C_resolution_x / 8;
  localparam logic [C_bits_x-1:0] BAR_W_X = C_bits_x'(BAR_W);

  if (BAR_W < 1 || C_bits_x < 8 || C_bits_y < 8 ||
      C_checker_log2 >= C_bits_x || C_checker_log2 >= C_bits_y) begin : g_bad_params
    $error("video_timing_pattern: need res_x >= 8, counters >= 8 bits, checker bit inside counters");
  end

  logic [C_bits_x-1:0] w_hcount;
  logic [C_bits_y-1:0] w_vcount;
  logic                w_hsync, w_vsync, w_blank, w_line_first, w_frame_first;

  video_raster_counter #(
    .C_resolution_x     (C_resolution_x),
    .C_hsync_front_porch(C_hsync_front_porch),
    .C_hsync_pulse      (C_hsync_pulse),
    .C_hsync_back_porch (C_hsync_back_porch),
    .C_resolution_y     (C_resolution_y),
    .C_vsync_front_porch(C_vsync_front_porch),
    .C_vsync_pulse      (C_vsync_pulse),
    .C_vsync_back_porch (C_vsync_back_porch),
    .C_hsync_polarity   (C_hsync_polarity),
    .C_vsync_polarity   (C_vsync_polarity),
    .C_bits_x           (C_bits_x),
    .C_bits_y           (C_bits_y)
  ) u_raster (
    .i_clk        (clk_pixel),
    .i_rst        (reset),
    .o_hcount     (w_hcount),
    .o_vcount     (w_vcount),
    .o_hsync      (w_hsync),
    .o_vsync      (w_vsync),
    .o_blank      (w_blank),
    .o_line_first (w_line_first),
    .o_frame_first(w_frame_first)
  );

  logic [1:0]          r_mode;
  logic [23:0]         r_solid;
  logic [7:0]          r_frame_count;
  logic [1:0]          w_mode;
  logic [23:0]         w_solid;
  logic [7:0]          w_fc_next;
  logic [C_bits_x-1:0] w_bar_q;
  logic [2:0]          w_bar;
  logic [7:0]          w_grad_r;
  logic                w_checker;
  logic [23:0]         w_rgb;

  // Pixel (0,0) already uses the freshly sampled mode and the incremented frame count.
  assign w_mode    = w_frame_first ? mode : r_mode;
  assign w_solid   = w_frame_first ? solid_rgb : r_solid;
  assign w_fc_next = w_frame_first ? r_frame_count + 8'd1 : r_frame_count;

  // Pixels past the last full bar stay in bar 7.
  assign w_bar_q   = w_hcount / BAR_W_X;
  assign w_bar     = (w_bar_q > C_bits_x'(7)) ? 3'd7 : w_bar_q[2:0];
  assign w_grad_r  = w_hcount[7:0] + w_fc_next;
  assign w_checker = w_hcount[C_checker_log2] ^ w_vcount[C_checker_log2];

  // Pattern mux; blanked pixels are always black.
  always_comb begin
    w_rgb = '0;
    if (!w_blank) begin
      case (pattern_e'(w_mode))
        PAT_BARS:     w_rgb = bar_colour(w_bar);
        PAT_CHECKER:  w_rgb = {24{w_checker}};
        PAT_GRADIENT: w_rgb = {w_grad_r, w_vcount[7:0], w_grad_r ^ w_vcount[7:0]};
        PAT_SOLID:    w_rgb = w_solid;
        default:      w_rgb = '0;
      endcase
    end
  end

  // Frame-latched pattern settings and frame counter.
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      r_mode        <= 2'd0;
      r_solid       <= '0;
      r_frame_count <= '0;
    end else begin
      r_mode        <= w_mode;
      r_solid       <= w_solid;
      r_frame_count <= w_fc_next;
    end
  end

  // Output register stage keeping timing, coordinates and colour aligned.
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hsync   <= ~C_hsync_polarity;
      vga_vsync   <= ~C_vsync_polarity;
      vga_blank   <= 1'b1;
      pixel_x     <= '0;
      pixel_y     <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      vga_r       <= w_rgb[23:16];
      vga_g       <= w_rgb[15:8];
      vga_b       <= w_rgb[7:0];
      vga_hsync   <= w_hsync;
      vga_vsync   <= w_vsync;
      vga_blank   <= w_blank;
      pixel_x     <= w_hcount;
      pixel_y     <= w_vcount;
      line_start  <= w_line_first;
      frame_start <= w_frame_first;
    end
  end

  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_video_timing_pattern.sv
// Bench for video_timing_pattern: two small timing sets, a cycle-accurate reference
// scoreboard, a table of pattern vectors and hand-written multi-cycle sequences.
module tb_video_timing_pattern;

  typedef struct packed {
    logic [7:0]  r, g, b;
    logic        hs, vs, bl;
    logic [11:0] x;
    logic [10:0] y;
    logic        ls, fs;
    logic [7:0]  fc;
  } obs_t;

  typedef struct {
    logic [1:0]  mode;
    logic [23:0] solid;
    int          x, y;
    logic [23:0] rgb;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;
  logic [1:0]  mode_a, mode_b;
  logic [23:0] solid_a, solid_b;
  logic [7:0]  a_r, a_g, a_b, b_r, b_g, b_b;
  logic        a_hs, a_vs, a_bl, a_ls, a_fs, b_hs, b_vs, b_bl, b_ls, b_fs;
  logic [11:0] a_x, b_x;
  logic [10:0] a_y, b_y;
  logic [7:0]  a_fc, b_fc;

  // Set A: 16x4, H 2/3/1, V 1/1/1, active-low syncs.
  video_timing_pattern #(
    .C_resolution_x(16), .C_hsync_front_porch(2), .C_hsync_pulse(3), .C_hsync_back_porch(1),
    .C_resolution_y(4),  .C_vsync_front_porch(1), .C_vsync_pulse(1), .C_vsync_back_porch(1),
    .C_hsync_polarity(1'b0), .C_vsync_polarity(1'b0), .C_checker_log2(5), .C_bits_x(12), .C_bits_y(11)
  ) dut_a (
    .clk_pixel(clk), .reset(rst_a), .mode(mode_a), .solid_rgb(solid_a),
    .vga_r(a_r), .vga_g(a_g), .vga_b(a_b), .vga_hsync(a_hs), .vga_vsync(a_vs), .vga_blank(a_bl),
    .pixel_x(a_x), .pixel_y(a_y), .line_start(a_ls), .frame_start(a_fs), .frame_count(a_fc)
  );

  // Set B: 20x8, H 2/3/1, V 1/1/1, active-high syncs, 4-pixel checker.
  video_timing_pattern #(
    .C_resolution_x(20), .C_hsync_front_porch(2), .C_hsync_pulse(3), .C_hsync_back_porch(1),
    .C_resolution_y(8),  .C_vsync_front_porch(1), .C_vsync_pulse(1), .C_vsync_back_porch(1),
    .C_hsync_polarity(1'b1), .C_vsync_polarity(1'b1), .C_checker_log2(2), .C_bits_x(12), .C_bits_y(11)
  ) dut_b (
    .clk_pixel(clk), .reset(rst_b), .mode(mode_b), .solid_rgb(solid_b),
    .vga_r(b_r), .vga_g(b_g), .vga_b(b_b), .vga_hsync(b_hs), .vga_vsync(b_vs), .vga_blank(b_bl),
    .pixel_x(b_x), .pixel_y(b_y), .line_start(b_ls), .frame_start(b_fs), .frame_count(b_fc)
  );

  obs_t obs_a, obs_b;
  assign obs_a = {a_r, a_g, a_b, a_hs, a_vs, a_bl, a_x, a_y, a_ls, a_fs, a_fc};
  assign obs_b = {b_r, b_g, b_b, b_hs, b_vs, b_bl, b_x, b_y, b_ls, b_fs, b_fc};

  int nchk = 0;
  int nfail = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    nchk++;
    if (got !== want) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic timeout(input string nm);
    nchk++;
    nfail++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  function automatic obs_t get_obs(input int d);
    return (d == 0) ? obs_a : obs_b;
  endfunction

  function automatic logic get_rst(input int d);
    return (d == 0) ? rst_a : rst_b;
  endfunction

  function automatic obs_t rst_obs(input int d);
    obs_t o;
    o    = '0;
    o.bl = 1'b1;
    o.hs = (d == 0) ? 1'b1 : 1'b0;
    o.vs = (d == 0) ? 1'b1 : 1'b0;
    return o;
  endfunction

  function automatic logic [23:0] ref_bar(input int i);
    case (i)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // Reference model state, one slot per DUT.
  int          m_h[2], m_v[2];
  logic [7:0]  m_fc[2];
  logic [1:0]  m_mode[2];
  logic [23:0] m_solid[2];
  obs_t        q_a[$], q_b[$];

  task automatic model_reset(input int d);
    m_h[d] = 0; m_v[d] = 0; m_fc[d] = 8'd0; m_mode[d] = 2'd0; m_solid[d] = 24'd0;
  endtask

  task automatic model_step(input int d, output obs_t e);
    int rx, ry, hfp, hp, hbp, vfp, vp, vbp, cl, h, v, bi;
    logic pol;
    logic [7:0] rr, gg;
    logic [23:0] c;
    if (d == 0) begin rx = 16; ry = 4; pol = 1'b0; cl = 5; end
    else        begin rx = 20; ry = 8; pol = 1'b1; cl = 2; end
    hfp = 2; hp = 3; hbp = 1; vfp = 1; vp = 1; vbp = 1;
    h = m_h[d]; v = m_v[d];
    e    = '0;
    e.x  = h[11:0];
    e.y  = v[10:0];
    e.bl = (h >= rx) || (v >= ry);
    e.hs = (h >= rx + hfp && h < rx + hfp + hp) ? pol : ~pol;
    e.vs = (v >= ry + vfp && v < ry + vfp + vp) ? pol : ~pol;
    e.ls = (h == 0);
    e.fs = (h == 0) && (v == 0);
    if (e.fs) begin
      m_fc[d]    = m_fc[d] + 8'd1;
      m_mode[d]  = (d == 0) ? mode_a : mode_b;
      m_solid[d] = (d == 0) ? solid_a : solid_b;
    end
    e.fc = m_fc[d];
    c = 24'd0;
    case (m_mode[d])
      2'd0: begin bi = h / (rx / 8); if (bi > 7) bi = 7; c = ref_bar(bi); end
      2'd1: c = ((((h >> cl) & 1) ^ ((v >> cl) & 1)) != 0) ? 24'hFFFFFF : 24'h000000;
      2'd2: begin rr = h[7:0] + m_fc[d]; gg = v[7:0]; c = {rr, gg, rr ^ gg}; end
      default: c = m_solid[d];
    endcase
    if (e.bl) c = 24'd0;
    {e.r, e.g, e.b} = c;
    h++;
    if (h == rx + hfp + hp + hbp) begin
      h = 0;
      v++;
      if (v == ry + vfp + vp + vbp) v = 0;
    end
    m_h[d] = h; m_v[d] = v;
  endtask

  // Push the expected output for every clock the DUT advances.
  always @(posedge clk) begin
    obs_t e;
    if (rst_a) model_reset(0);
    else begin model_step(0, e); q_a.push_back(e); end
    if (rst_b) model_reset(1);
    else begin model_step(1, e); q_b.push_back(e); end
  end

  // Compare registered outputs mid-cycle against the scoreboard or the reset state.
  always @(negedge clk) begin
    obs_t e;
    if (rst_a) begin q_a.delete(); chk("reset_a", obs_a, rst_obs(0)); end
    else if (q_a.size() > 0) begin e = q_a.pop_front(); chk("sb_a", obs_a, e); end
    if (rst_b) begin q_b.delete(); chk("reset_b", obs_b, rst_obs(1)); end
    else if (q_b.size() > 0) begin e = q_b.pop_front(); chk("sb_b", obs_b, e); end
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic wait_pix(input int d, input int x, input int y);
    obs_t o;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      o = get_obs(d);
      if (!get_rst(d) && o.x == 12'(x) && o.y == 11'(y)) return;
    end
    timeout($sformatf("wait_pix d%0d (%0d,%0d)", d, x, y));
  endtask

  vec_t tbl[13];

  initial begin
    int n;
    logic found;
    tbl[0]  = '{2'd0, 24'h0,      0,  0, 24'hFFFFFF};
    tbl[1]  = '{2'd0, 24'h0,      2,  0, 24'hFFFF00};
    tbl[2]  = '{2'd0, 24'h0,     13,  1, 24'h0000FF};
    tbl[3]  = '{2'd0, 24'h0,     14,  1, 24'h000000};
    tbl[4]  = '{2'd0, 24'h0,     19,  2, 24'h000000};
    tbl[5]  = '{2'd0, 24'h0,     20,  2, 24'h000000};
    tbl[6]  = '{2'd0, 24'h0,      5,  8, 24'h000000};
    tbl[7]  = '{2'd1, 24'h0,      4,  0, 24'hFFFFFF};
    tbl[8]  = '{2'd1, 24'h0,      4,  4, 24'h000000};
    tbl[9]  = '{2'd1, 24'h0,      0,  0, 24'h000000};
    tbl[10] = '{2'd1, 24'h0,      0,  4, 24'hFFFFFF};
    tbl[11] = '{2'd3, 24'hABCDEF, 7,  3, 24'hABCDEF};
    tbl[12] = '{2'd3, 24'hABCDEF, 21, 3, 24'h000000};

    rst_a = 1'b1; rst_b = 1'b1;
    mode_a = 2'd0; mode_b = 2'd2;
    solid_a = 24'd0; solid_b = 24'd0;
    tick(); tick();
    rst_a = 1'b0; rst_b = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("first_fs_a", a_fs, 1'b1);
    chk("first_fc_a", a_fc, 8'd1);
    chk("first_xy_a", {a_x, a_y}, 23'd0);
    chk("first_fc_b", b_fc, 8'd1);

    // Gradient on set B at frame 3.
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      found = (b_fc == 8'd3 && b_x == 12'd10 && b_y == 11'd7);
    end
    if (found) chk("grad_10_7", {b_r, b_g, b_b}, 24'h0D070A);
    else timeout("grad_10_7");

    // Set A sync and blank placement.
    wait_pix(0, 17, 1); chk("hs_x17", a_hs, 1'b1);
    wait_pix(0, 18, 1); chk("hs_x18", a_hs, 1'b0);
    wait_pix(0, 20, 1); chk("hs_x20", a_hs, 1'b0);
    wait_pix(0, 21, 1); chk("hs_x21", a_hs, 1'b1);
    wait_pix(0, 15, 3); chk("bl_15_3", a_bl, 1'b0);
    wait_pix(0, 21, 4); chk("vs_y4", a_vs, 1'b1);
    wait_pix(0, 0, 4);  chk("bl_0_4", a_bl, 1'b1);
    wait_pix(0, 0, 5);  chk("vs_y5_x0", a_vs, 1'b0);
    wait_pix(0, 21, 5); chk("vs_y5_x21", a_vs, 1'b0);
    wait_pix(0, 0, 6);  chk("vs_y6", a_vs, 1'b1);
    wait_pix(0, 16, 0); chk("bl_16_0", a_bl, 1'b1);
    wait_pix(0, 0, 0);
    n = 0;
    do begin @(negedge clk); n++; end while (!a_fs && n < 400);
    chk("frame_period", n, 154);

    // Asynchronous reset in the middle of a line.
    wait_pix(0, 9, 2);
    #2 rst_a = 1'b1;
    #1 chk("async_reset", obs_a, rst_obs(0));
    tick(); tick();
    rst_a = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("rel_fs", a_fs, 1'b1);
    chk("rel_fc", a_fc, 8'd1);

    // Mode change mid-frame only takes effect at the next frame.
    wait_pix(0, 5, 1);
    #2 mode_a = 2'd3; solid_a = 24'h123456;
    wait_pix(0, 6, 1);  chk("keep_bars_6_1", {a_r, a_g, a_b}, 24'h00FF00);
    wait_pix(0, 3, 3);  chk("keep_bars_3_3", {a_r, a_g, a_b}, 24'hFFFF00);
    wait_pix(0, 0, 0);  chk("solid_0_0", {a_r, a_g, a_b}, 24'h123456);
    wait_pix(0, 9, 2);  chk("solid_9_2", {a_r, a_g, a_b}, 24'h123456);
    wait_pix(0, 16, 0); chk("solid_blank", {a_r, a_g, a_b}, 24'h000000);

    // Set B sync polarity.
    wait_pix(1, 0, 0);  chk("b_hs_idle", b_hs, 1'b0);
    chk("b_vs_idle", b_vs, 1'b0);
    wait_pix(1, 22, 0); chk("b_hs_pulse", b_hs, 1'b1);
    wait_pix(1, 0, 9);  chk("b_vs_pulse", b_vs, 1'b1);

    // Pattern vector table on set B.
    foreach (tbl[k]) begin
      mode_b = tbl[k].mode;
      solid_b = tbl[k].solid;
      wait_pix(1, 0, 0);
      if (tbl[k].x != 0 || tbl[k].y != 0) wait_pix(1, tbl[k].x, tbl[k].y);
      chk($sformatf("tbl%0d", k), {b_r, b_g, b_b}, tbl[k].rgb);
    end

    // Gradient across the frame counter wrap on set A.
    mode_a = 2'd2;
    found = 1'b0;
    for (int i = 0; i < 300 * 154 && !found; i++) begin
      @(negedge clk);
      found = (a_fc == 8'd255);
    end
    if (!found) timeout("fc_255");
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      found = (a_fc == 8'd0 && a_x == 12'd3 && a_y == 11'd1);
    end
    if (found) chk("grad_wrap_3_1", {a_r, a_g, a_b}, 24'h030102);
    else timeout("fc_wrap");

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
